// File: rtl/div_unit_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative RV32M divide unit.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? neg2c(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN+1:0] shifted_s;
  logic [XLEN+1:0] trial_s;

  // Shift in the next dividend bit, trial-subtract, restore when the result goes negative.
  always_comb begin
    shifted_s = {rem_in, quo_in[XLEN-1]};
    trial_s   = shifted_s - {2'b00, divisor};
    if (trial_s[XLEN+1]) begin
      rem_out = shifted_s[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = trial_s[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one quotient bit per cycle, result held until
// the write-back stage accepts it.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  input  logic            result_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            rf_we
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t          state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN:0]   rem_r;
  logic [XLEN-1:0] quo_r, dvs_r, result_r;
  logic [4:0]      rd_r;
  logic            is_rem_r, neg_q_r, neg_r_r;

  logic            signed_op_s, is_rem_s, a_neg_s, b_neg_s;
  logic            div_zero_s, ovf_s, special_s, last_step_s;
  logic [XLEN-1:0] special_res_s, final_res_s;
  logic [XLEN:0]   rem_nxt_s;
  logic [XLEN-1:0] quo_nxt_s;

  div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvs_r),
    .rem_out (rem_nxt_s),
    .quo_out (quo_nxt_s)
  );

  // Decode the incoming op and classify the operands that bypass the iteration.
  always_comb begin
    signed_op_s = 1'b0;
    is_rem_s    = 1'b0;
    case (op)
      OP_DIV:  begin signed_op_s = 1'b1; is_rem_s = 1'b0; end
      OP_DIVU: begin signed_op_s = 1'b0; is_rem_s = 1'b0; end
      OP_REM:  begin signed_op_s = 1'b1; is_rem_s = 1'b1; end
      OP_REMU: begin signed_op_s = 1'b0; is_rem_s = 1'b1; end
      default: begin signed_op_s = 1'b0; is_rem_s = 1'b0; end
    endcase
    a_neg_s    = signed_op_s & rs1_val[XLEN-1];
    b_neg_s    = signed_op_s & rs2_val[XLEN-1];
    div_zero_s = (rs2_val == {XLEN{1'b0}});
    ovf_s      = signed_op_s & (rs1_val == SIGNED_MIN) & (rs2_val == DIV_ZERO_Q);
    special_s  = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_res_s = is_rem_s ? rs1_val : DIV_ZERO_Q;
    end else begin
      special_res_s = is_rem_s ? {XLEN{1'b0}} : SIGNED_MIN;
    end
  end

  assign last_step_s = (cnt_r == CNT_LAST);
  assign final_res_s = is_rem_r ? cond_neg(rem_nxt_s[XLEN-1:0], neg_r_r)
                                : cond_neg(quo_nxt_s, neg_q_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush beats everything except reset.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (flush || !start) begin
          state_nxt_s = ST_IDLE;
        end else if (special_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (flush || result_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; a flush in DONE suppresses the write.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    case (state_r)
      ST_IDLE: begin busy = 1'b0; done = 1'b0; end
      ST_BUSY: begin busy = 1'b1; done = 1'b0; end
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
    rf_we  = done & result_ready & ~flush;
    result = result_r;
    rd_out = rd_r;
  end

  // Operand capture, iteration and result fixup.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {(XLEN+1){1'b0}};
      quo_r    <= {XLEN{1'b0}};
      dvs_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      rd_r     <= 5'd0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !flush) begin
            rd_r     <= rd_in;
            is_rem_r <= is_rem_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            quo_r    <= cond_neg(rs1_val, a_neg_s);
            dvs_r    <= cond_neg(rs2_val, b_neg_s);
            rem_r    <= {(XLEN+1){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            if (special_s) begin
              result_r <= special_res_s;
            end
          end
        end
        ST_BUSY: begin
          if (!flush) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (last_step_s) begin
              result_r <= final_res_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, randomized ops against an
// arithmetic reference model, and hand-written abort/backpressure sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, result_ready;
  logic [1:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done, rf_we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_in(rd_in), .flush(flush), .result_ready(result_ready), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .rf_we(rf_we)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: plain integer division with RISC-V rules for the exceptional cases.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit is_rem;
    is_rem = o[1];
    sa = a;
    sb = b;
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Full transaction: start, latency check, optional backpressure, single write pulse.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int hold, input string nm);
    int n;
    int exp_lat;
    exp_lat = is_special(o, a, b) ? 0 : 32;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_in = ~rd;
    chk({nm, ":busy"}, busy, 1'b1);
    wait_done(n);
    chk({nm, ":lat"}, 32'(n), 32'(exp_lat));
    chk({nm, ":done"}, done, 1'b1);
    chk({nm, ":result"}, result, exp);
    chk({nm, ":rd"}, rd_out, rd);
    chk({nm, ":we_hold"}, rf_we, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, ":bp_done"}, done, 1'b1);
      chk({nm, ":bp_result"}, result, exp);
      chk({nm, ":bp_rd"}, rd_out, rd);
      chk({nm, ":bp_we"}, rf_we, 1'b0);
    end
    result_ready = 1'b1; #1;
    chk({nm, ":we"}, rf_we, 1'b1);
    @(posedge clk); #1;
    chk({nm, ":we_off"}, rf_we, 1'b0);
    chk({nm, ":idle"}, busy, 1'b0);
    result_ready = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    int n, seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{OP_DIV,  32'd100,         32'd7,           32'd14};
    tbl[1]  = '{OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF};
    tbl[2]  = '{OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD};
    tbl[3]  = '{OP_REMU, 32'hFFFF_FFF9,   32'd2,           32'd1};
    tbl[4]  = '{OP_DIVU, 32'd5,           32'd0,           32'hFFFF_FFFF};
    tbl[5]  = '{OP_REM,  32'd5,           32'd0,           32'd5};
    tbl[6]  = '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
    tbl[7]  = '{OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
    tbl[8]  = '{OP_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF};
    tbl[9]  = '{OP_REMU, 32'd7,           32'd0,           32'd7};
    tbl[10] = '{OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF};
    tbl[11] = '{OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1};
    tbl[12] = '{OP_DIV,  32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD};
    tbl[13] = '{OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
    tbl[14] = '{OP_REMU, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
    tbl[15] = '{OP_REM,  32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'hFFFF_FFFE};

    rst = 1'b1; start = 1'b0; flush = 1'b0; result_ready = 1'b0;
    op = 2'b00; rs1_val = 32'd0; rs2_val = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:we", rf_we, 1'b0);
    chk("rst:result", result, 32'd0);
    chk("rst:rd", rd_out, 5'd0);
    rst = 1'b0;

    do_op(tbl[0].op, tbl[0].a, tbl[0].b, 5'd10, tbl[0].exp, 5, "div100_7");
    for (int i = 1; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i), tbl[i].exp, 0, $sformatf("tbl%0d", i));
    end

    // start pulsed in BUSY must not disturb the running divide
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd10; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_DIV; rs1_val = 32'd1; rs2_val = 32'd1; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("busy_start:lat", 32'(n + 5), 32'd32);
    chk("busy_start:result", result, 32'd10);
    chk("busy_start:rd", rd_out, 5'd3);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;

    // flush in the 10th BUSY cycle, with the write port ready throughout
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy:busy", busy, 1'b0);
    chk("flush_busy:done", done, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rf_we || done) seen++;
      @(posedge clk); #1;
    end
    chk("flush_busy:no_we", 32'(seen), 32'd0);
    result_ready = 1'b0;

    // flush in DONE while result_ready is high: no write
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_val = 32'd9; rs2_val = 32'd3; rd_in = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("flush_done:done", done, 1'b1);
    flush = 1'b1; result_ready = 1'b1; #1;
    chk("flush_done:we", rf_we, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; result_ready = 1'b0;
    chk("flush_done:busy", busy, 1'b0);
    chk("flush_done:done_off", done, 1'b0);

    // flush beats a simultaneous start
    start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1_val = 32'd8; rs2_val = 32'd2; rd_in = 5'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start:busy", busy, 1'b0);
    chk("flush_start:done", done, 1'b0);

    // reset in the middle of BUSY
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'd17; rd_in = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy:busy", busy, 1'b0);
    chk("rst_busy:done", done, 1'b0);
    chk("rst_busy:we", rf_we, 1'b0);
    chk("rst_busy:result", result, 32'd0);
    chk("rst_busy:rd", rd_out, 5'd0);
    do_op(OP_DIVU, 32'd9, 32'd3, 5'd12, 32'd3, 0, "divu9_3");

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      do_op(ro, ra, rb, 5'($urandom_range(0, 31)), ref_model(ro, ra, rb), 0,
            $sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
